// File: rtl/mdu_if.sv
//------------------------------------------------------------------------------
// mdu_if : request/response handshake and ALU time-share bus of mdu_seq
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mdu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] alu_out;

    // Sequencer side
    modport slave (
        input  in_valid, op, a, b, out_ready, alu_out,
        output in_ready, out_valid, result, alu_op1, alu_op2, alu_ctrl
    );

    // Core side, which also owns the ALU
    modport master (
        output in_valid, op, a, b, out_ready, alu_out,
        input  in_ready, out_valid, result, alu_op1, alu_op2, alu_ctrl
    );
endinterface

`default_nettype wire

// File: rtl/mdu_seq.sv
//------------------------------------------------------------------------------
// mdu_seq : multi-cycle unsigned MUL/DIVU/REMU sequencer sharing the core ALU.
//           Optional MDU_ZERO_EARLY_EN: zero operands skip the iteration loop.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_seq #(
    parameter int XLEN = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mdu_if.slave      bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_MUL     = 3'd1;
    localparam logic [2:0] c_DIV_CMP = 3'd2;
    localparam logic [2:0] c_DIV_SUB = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_SLTU = 3'b101;

    localparam logic [CW-1:0] c_LAST = CW'(XLEN - 1);

    logic [2:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sel_rem;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mc;
    logic [XLEN-1:0] r_mp;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dv;
    logic            r_lt;
    logic [XLEN-1:0] r_result;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_last;
    logic            w_top;
    logic [XLEN-1:0] w_rsh;
    logic            w_ge;
    logic [XLEN-1:0] w_acc_nxt;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic            w_early;
    logic [XLEN-1:0] w_early_res;
    logic [XLEN-1:0] w_alu_op1;
    logic [XLEN-1:0] w_alu_op2;
    logic [2:0]      w_alu_ctrl;

    assign w_accept = bus.in_valid && (r_state == c_IDLE);
    assign w_last   = (r_cnt == c_LAST);

    // Restoring-division step: the remainder shifted left by one with the next dividend bit
    assign w_top     = r_rem[XLEN-1];
    assign w_rsh     = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_ge      = w_top | ~r_lt;
    assign w_rem_nxt = w_ge ? bus.alu_out : w_rsh;
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    assign w_acc_nxt = r_mp[0] ? bus.alu_out : r_acc;

`ifdef MDU_ZERO_EARLY_EN
    assign w_early     = bus.op[1] ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
    assign w_early_res = bus.op[1] ? (bus.op[0] ? bus.a : '1) : '0;
`else
    assign w_early     = 1'b0;
    assign w_early_res = '0;
`endif

    always_comb begin
        w_alu_op1  = '0;
        w_alu_op2  = '0;
        w_alu_ctrl = c_ALU_ADD;
        case (r_state)
            c_MUL: begin
                w_alu_op1 = r_acc;
                w_alu_op2 = r_mc;
            end
            c_DIV_CMP: begin
                w_alu_op1  = w_rsh;
                w_alu_op2  = r_dv;
                w_alu_ctrl = c_ALU_SLTU;
            end
            c_DIV_SUB: begin
                w_alu_op1  = w_rsh;
                w_alu_op2  = r_dv;
                w_alu_ctrl = c_ALU_SUB;
            end
            default: ;
        endcase
    end

    assign bus.alu_op1   = w_alu_op1;
    assign bus.alu_op2   = w_alu_op2;
    assign bus.alu_ctrl  = w_alu_ctrl;
    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_sel_rem   <= 1'b0;
            r_acc       <= '0;
            r_mc        <= '0;
            r_mp        <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dv        <= '0;
            r_lt        <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_sel_rem <= bus.op[0];
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_mc      <= bus.a;
                        r_mp      <= bus.b;
                        r_rem     <= '0;
                        r_quo     <= bus.a;
                        r_dv      <= bus.b;
                        if (w_early) begin
                            r_result    <= w_early_res;
                            r_out_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_state <= bus.op[1] ? c_DIV_CMP : c_MUL;
                        end
                    end
                end
                c_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_mc  <= r_mc << 1;
                    r_mp  <= r_mp >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result    <= w_acc_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DIV_CMP: begin
                    r_lt    <= bus.alu_out[0];
                    r_state <= c_DIV_SUB;
                end
                c_DIV_SUB: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result    <= r_sel_rem ? w_rem_nxt : w_quo_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_state <= c_DIV_CMP;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
//------------------------------------------------------------------------------
// tb_mdu_seq : scoreboard bench for mdu_seq with a behavioural ALU model
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mdu_seq;
    localparam int XLEN = 32;
    localparam logic [1:0] c_OP_MUL  = 2'b00;
    localparam logic [1:0] c_OP_DIVU = 2'b10;
    localparam logic [1:0] c_OP_REMU = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if #(.XLEN(XLEN)) bus();

    mdu_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_comb begin
        bus.alu_out = '0;
        case (bus.alu_ctrl)
            3'b000:  bus.alu_out = bus.alu_op1 + bus.alu_op2;
            3'b001:  bus.alu_out = bus.alu_op1 - bus.alu_op2;
            3'b101:  bus.alu_out = {31'b0, (bus.alu_op1 < bus.alu_op2)};
            default: bus.alu_out = '0;
        endcase
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        if (!op[1])   return p[31:0];
        if (b == 0)   return op[0] ? a : 32'hFFFF_FFFF;
        return op[0] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_ZERO_EARLY_EN
        if (op[1] && b == 0) return 1;
        if (!op[1] && (a == 0 || b == 0)) return 1;
`endif
        return op[1] ? 65 : 33;
    endfunction

    // Retirement monitor: result compared when the handshake completes
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
            else                check_eq("result", bus.result, sb.pop_front());
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int t;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check_eq("in_ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        sb.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    // Clocks from the accept edge to the first edge that sees out_valid high
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = j + 1;
                break;
            end
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        int lat;
        issue(op, a, b, exp);
        wait_valid(lat);
        check_eq("latency", 32'(lat), 32'(exp_lat(op, a, b)));
        if (lat != 0) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("ov_width", {31'b0, bus.out_valid}, 32'd0);
        end
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("rst_result",    bus.result, 32'd0);
        check_eq("rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
        check_eq("rst_alu_ctrl",  {29'b0, bus.alu_ctrl}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(c_OP_MUL,  32'd7,         32'd6,         32'd42);
        run(c_OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run(c_OP_MUL,  32'h8000_0000, 32'd2,         32'h0000_0000);
        run(c_OP_MUL,  32'd0,         32'd12345,     32'd0);
        run(c_OP_DIVU, 32'd100,       32'd7,         32'd14);
        run(c_OP_REMU, 32'd100,       32'd7,         32'd2);
        run(c_OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF);
        run(c_OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF);
        run(c_OP_REMU, 32'd5,         32'd0,         32'd5);
        run(c_OP_REMU, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001);
        run(c_OP_DIVU, 32'hFFFF_FFFE, 32'h8000_0001, 32'd1);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            run(2'(i % 4), ra, rb, model(2'(i % 4), ra, rb));
        end

        // Result held while the consumer stalls; new requests are ignored
        bus.out_ready = 1'b0;
        issue(c_OP_DIVU, 32'd1000, 32'd3, 32'd333);
        wait_valid(lat);
        check_eq("hold_latency", 32'(lat), 32'd65);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.op       = c_OP_MUL;
            bus.a        = 32'd9;
            bus.b        = 32'd9;
            @(negedge clk);
            check_eq("hold_ov",       {31'b0, bus.out_valid}, 32'd1);
            check_eq("hold_result",   bus.result, 32'd333);
            check_eq("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("retire_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check_eq("retire_ov",       {31'b0, bus.out_valid}, 32'd0);

        // Reset in the middle of a divide drops it
        issue(c_OP_DIVU, 32'hDEAD_BEEF, 32'd3, 32'hDEAD_BEEF / 32'd3);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check_eq("mid_rst_ov",       {31'b0, bus.out_valid}, 32'd0);
        check_eq("mid_rst_result",   bus.result, 32'd0);
        check_eq("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        run(c_OP_MUL, 32'd3, 32'd4, 32'd12);

        repeat (3) @(posedge clk);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
